// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/allowin pipeline stage, plain register or two-entry skid buffer
module pipe_stage_buf #(
  parameter int DW = 64,
  parameter int SKID = 0,
  parameter logic [DW-1:0] RST_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_allowin,
  input  logic          ready_go,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_allowin,
  output logic          stage_valid,
  output logic [1:0]    occ
);
  logic          head_v, skid_v, allow_q;
  logic [DW-1:0] head_d, skid_d;
  logic          acc, drain, head_ld_in, head_ld_skid, skid_ld, head_v_n, skid_v_n;
  assign stage_valid = head_v;
  assign out_valid   = head_v && ready_go;
  assign out_data    = head_d;
  assign occ         = {1'b0, head_v} + {1'b0, skid_v};
  assign drain       = out_valid && out_allowin;
  // skid mode exposes only the flop, cutting the path from downstream back to upstream
  assign in_allowin  = (SKID != 0) ? allow_q : (!head_v || drain);
  assign acc         = in_valid && in_allowin;
  always_comb begin
    head_ld_in   = acc && (!head_v || (drain && !skid_v));
    head_ld_skid = drain && skid_v;
    skid_ld      = (SKID != 0) && acc && head_v && (!drain || skid_v);
    head_v_n     = acc || (drain ? skid_v : head_v);
    skid_v_n     = skid_ld ? 1'b1 : (head_ld_skid ? 1'b0 : skid_v);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_v  <= 1'b0;
      skid_v  <= 1'b0;
      allow_q <= 1'b1;
      head_d  <= RST_VAL;
      skid_d  <= RST_VAL;
    end else begin
      head_v  <= !flush && head_v_n;
      skid_v  <= !flush && skid_v_n;
      allow_q <= flush || !(head_v_n && skid_v_n);
      if (head_ld_in) head_d <= in_data;
      else if (head_ld_skid) head_d <= skid_d;
      if (skid_ld) skid_d <= in_data;
    end
  end
endmodule
